regfile_mp_scoreboard: RTL and testbench

//  Parametrised multi-port integer register file with per-register pending (scoreboard) bits.

---
 rtl/regfile_mp_scoreboard_if.sv | 36 +++
 rtl/regfile_mp_scoreboard.sv | 105 ++++++++++
 tb/tb_regfile_mp_scoreboard.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_scoreboard_if.sv
// Bus bundle for the multi-port register file with scoreboard.
// master drives requests; slave is the register file.
interface regfile_mp_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2
);
  logic                  enable;
  logic [NRD-1:0]        rd_en;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [NWR-1:0]        wr_en;
  logic [NWR*ADDR_W-1:0] wr_addr;
  logic [NWR*DATA_W-1:0] wr_data;
  logic                  rsv_en;
  logic [ADDR_W-1:0]     rsv_addr;
  logic                  flush;
  logic [NREG-1:0]       busy_vec;

  modport master (
    output enable, rd_en, rd_addr,
    output wr_en, wr_addr, wr_data,
    output rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  enable, rd_en, rd_addr,
    input  wr_en, wr_addr, wr_data,
    input  rsv_en, rsv_addr, flush,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with per-register pending bits,
// write-through bypass and optional hardwired zero register.
module regfile_mp_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic clk,
  input logic rst,
  regfile_mp_scoreboard_if.slave bus
);

  logic [DATA_W-1:0]     regs [NREG];
  logic [NREG-1:0]       busy_q;
  logic [NREG-1:0]       busy_nxt;
  logic [NREG-1:0]       wr_hit;
  logic [DATA_W-1:0]     wr_val [NREG];
  logic [NRD*DATA_W-1:0] rd_d;
  logic [NRD-1:0]        rd_b;
  logic [NRD*DATA_W-1:0] rd_data_q;
  logic [NRD-1:0]        rd_busy_q;
  logic [ADDR_W-1:0]     ra [NRD];
  logic [ADDR_W-1:0]     wa [NWR];

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (int'(a) < NREG) && !(ZERO_REG != 0 && a == '0);
  endfunction

  for (genvar k = 0; k < NRD; k++) begin : g_ra
    assign ra[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
  end

  for (genvar j = 0; j < NWR; j++) begin : g_wa
    assign wa[j] = bus.wr_addr[j*ADDR_W +: ADDR_W];
  end

  // Ascending port scan: the last matching port, i.e. the highest index, wins.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      wr_hit[r] = 1'b0;
      wr_val[r] = '0;
      for (int j = 0; j < NWR; j++) begin
        if (bus.wr_en[j] && addr_ok(wa[j])
            && wa[j] == ADDR_W'(r)) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = bus.wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // A reservation outranks a same-cycle write: the newer producer is pending.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      busy_nxt[r] = busy_q[r];
      if (wr_hit[r])
        busy_nxt[r] = 1'b0;
      if (bus.rsv_en && addr_ok(bus.rsv_addr)
          && bus.rsv_addr == ADDR_W'(r))
        busy_nxt[r] = 1'b1;
      if (bus.flush)
        busy_nxt[r] = 1'b0;
    end
  end

  always_comb begin
    rd_d = '0;
    rd_b = '0;
    for (int k = 0; k < NRD; k++) begin
      if (bus.rd_en[k] && addr_ok(ra[k])) begin
        if (BYPASS != 0 && wr_hit[ra[k]])
          rd_d[k*DATA_W +: DATA_W] = wr_val[ra[k]];
        else
          rd_d[k*DATA_W +: DATA_W] = regs[ra[k]];
        rd_b[k] = busy_nxt[ra[k]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++)
        regs[r] <= '0;
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else if (bus.enable) begin
      for (int r = 0; r < NREG; r++)
        if (wr_hit[r])
          regs[r] <= wr_val[r];
      busy_q    <= busy_nxt;
      rd_data_q <= rd_d;
      rd_busy_q <= rd_b;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_busy  = rd_busy_q;
  assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Randomised and directed bench for regfile_mp_scoreboard,
// checked against an array-based reference model.
module tb_regfile_mp_scoreboard;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int ZR  = 1;
  localparam int BP  = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_scoreboard_if #(
    .DATA_W(DW), .ADDR_W(AW), .NREG(NR),
    .NRD(NRD), .NWR(NWR)
  ) bus ();

  regfile_mp_scoreboard #(
    .DATA_W(DW), .ADDR_W(AW), .NREG(NR),
    .NRD(NRD), .NWR(NWR),
    .ZERO_REG(ZR), .BYPASS(BP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]     mregs [NR];
  logic [NR-1:0]     mbusy;
  logic [NRD*DW-1:0] exp_rd;
  logic [NRD-1:0]    exp_rb;

  function automatic bit ok(int a);
    return a < NR && !(ZR != 0 && a == 0);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) mregs[r] = '0;
    mbusy  = '0;
    exp_rd = '0;
    exp_rb = '0;
  endtask

  task automatic model_step();
    logic [DW-1:0] nregs [NR];
    logic [NR-1:0] nbusy;
    int a;
    if (!bus.enable) return;
    for (int r = 0; r < NR; r++) nregs[r] = mregs[r];
    nbusy = mbusy;
    for (int j = 0; j < NWR; j++) begin
      a = int'(bus.wr_addr[j*AW +: AW]);
      if (bus.wr_en[j] && ok(a)) begin
        nregs[a] = bus.wr_data[j*DW +: DW];
        nbusy[a] = 1'b0;
      end
    end
    a = int'(bus.rsv_addr);
    if (bus.rsv_en && ok(a)) nbusy[a] = 1'b1;
    if (bus.flush) nbusy = '0;
    for (int k = 0; k < NRD; k++) begin
      a = int'(bus.rd_addr[k*AW +: AW]);
      if (bus.rd_en[k] && ok(a)) begin
        exp_rd[k*DW +: DW] = (BP != 0) ? nregs[a] : mregs[a];
        exp_rb[k] = nbusy[a];
      end else begin
        exp_rd[k*DW +: DW] = '0;
        exp_rb[k] = 1'b0;
      end
    end
    for (int r = 0; r < NR; r++) mregs[r] = nregs[r];
    mbusy = nbusy;
  endtask

  task automatic idle();
    bus.enable   = 1'b1;
    bus.rd_en    = '0;
    bus.rd_addr  = '0;
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_power_on();
    rst = 1'b0;
    idle();
    model_reset();
    #3;
    checks++;
    if (bus.rd_data !== '0 || bus.rd_busy !== '0
        || bus.busy_vec !== '0) begin
      errors++;
      $display("FAIL power_on got %h %b %h want 0",
               bus.rd_data, bus.rd_busy, bus.busy_vec);
    end
    #20;
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    idle();
    bus.wr_en   = 2'b01;
    bus.wr_addr = {AW'(0), AW'(5)};
    bus.wr_data = {32'h0, 32'hDEADBEEF};
    step();
    idle();
    bus.rd_en   = 2'b01;
    bus.rd_addr = {AW'(0), AW'(5)};
    step();
    checks++;
    if (bus.rd_data[DW-1:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic rd_data got %h want deadbeef",
               bus.rd_data[DW-1:0]);
    end
    checks++;
    if (bus.rd_data !== exp_rd || bus.rd_busy !== exp_rb) begin
      errors++;
      $display("FAIL basic_model got %h %b want %h %b",
               bus.rd_data, bus.rd_busy, exp_rd, exp_rb);
    end
  endtask

  task automatic test_conflict();
    idle();
    bus.wr_en   = 2'b11;
    bus.wr_addr = {AW'(7), AW'(7)};
    bus.wr_data = {32'h22, 32'h11};
    bus.rd_en   = 2'b10;
    bus.rd_addr = {AW'(7), AW'(0)};
    step();
    checks++;
    if (bus.rd_data[DW +: DW] !== 32'h22) begin
      errors++;
      $display("FAIL conflict_bypass got %h want 22",
               bus.rd_data[DW +: DW]);
    end
    idle();
    bus.rd_en   = 2'b01;
    bus.rd_addr = {AW'(0), AW'(7)};
    step();
    checks++;
    if (bus.rd_data[DW-1:0] !== 32'h22) begin
      errors++;
      $display("FAIL conflict_hold got %h want 22",
               bus.rd_data[DW-1:0]);
    end
  endtask

  task automatic test_zero();
    idle();
    bus.wr_en    = 2'b01;
    bus.wr_addr  = '0;
    bus.wr_data  = {32'h0, 32'hFFFF_FFFF};
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = '0;
    bus.rd_en    = 2'b10;
    step();
    checks++;
    if (bus.busy_vec[0] !== 1'b0 || bus.rd_data !== '0
        || bus.rd_busy !== '0) begin
      errors++;
      $display("FAIL zero_same got %b %h %b want 0 0 0",
               bus.busy_vec[0], bus.rd_data, bus.rd_busy);
    end
    idle();
    bus.rd_en = 2'b11;
    step();
    checks++;
    if (bus.rd_data !== '0 || bus.busy_vec !== mbusy) begin
      errors++;
      $display("FAIL zero_read got %h %h want 0 %h",
               bus.rd_data, bus.busy_vec, mbusy);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = AW'(3);
    step();
    checks++;
    if (bus.busy_vec[3] !== 1'b1) begin
      errors++;
      $display("FAIL sb_rsv got %b want 1", bus.busy_vec[3]);
    end
    bus.wr_en   = 2'b10;
    bus.wr_addr = {AW'(3), AW'(0)};
    bus.wr_data = {32'h33, 32'h0};
    bus.rd_en   = 2'b01;
    bus.rd_addr = {AW'(0), AW'(3)};
    step();
    checks++;
    if (bus.busy_vec[3] !== 1'b1 || bus.rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_rsv_wins got %b %b want 1 1",
               bus.busy_vec[3], bus.rd_busy[0]);
    end
    bus.rsv_en  = 1'b0;
    bus.wr_data = {32'h34, 32'h0};
    step();
    checks++;
    if (bus.busy_vec[3] !== 1'b0 || bus.rd_busy[0] !== 1'b0
        || bus.rd_data[DW-1:0] !== 32'h34) begin
      errors++;
      $display("FAIL sb_clear got %b %b %h want 0 0 34",
               bus.busy_vec[3], bus.rd_busy[0],
               bus.rd_data[DW-1:0]);
    end
  endtask

  task automatic test_enable_flush();
    idle();
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = AW'(12);
    step();
    bus.enable   = 1'b0;
    bus.rsv_addr = AW'(11);
    bus.wr_en    = 2'b11;
    bus.wr_addr  = {AW'(5), AW'(12)};
    bus.wr_data  = {32'h5555, 32'h1212};
    bus.rd_en    = 2'b11;
    bus.rd_addr  = {AW'(5), AW'(7)};
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.busy_vec !== mbusy || bus.rd_data !== exp_rd
          || bus.rd_busy !== exp_rb) begin
        errors++;
        $display("FAIL frozen got %h %h %b want %h %h %b",
                 bus.busy_vec, bus.rd_data, bus.rd_busy,
                 mbusy, exp_rd, exp_rb);
      end
    end
    idle();
    bus.flush    = 1'b1;
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = AW'(9);
    bus.rd_en    = 2'b11;
    bus.rd_addr  = {AW'(5), AW'(7)};
    step();
    checks++;
    if (bus.busy_vec !== '0) begin
      errors++;
      $display("FAIL flush got %h want 0", bus.busy_vec);
    end
    checks++;
    if (bus.rd_data !== {32'hDEADBEEF, 32'h22}) begin
      errors++;
      $display("FAIL frozen_regs got %h want deadbeef00000022",
               bus.rd_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.enable   = ($urandom_range(0, 9) != 0);
      bus.flush    = ($urandom_range(0, 24) == 0);
      bus.rsv_en   = $urandom_range(0, 1) == 1;
      bus.rsv_addr = AW'($urandom_range(0, 7));
      bus.wr_en    = NWR'($urandom);
      bus.rd_en    = NRD'($urandom);
      for (int j = 0; j < NWR; j++) begin
        bus.wr_addr[j*AW +: AW] = AW'($urandom_range(0, 7));
        bus.wr_data[j*DW +: DW] = $urandom;
      end
      for (int k = 0; k < NRD; k++)
        bus.rd_addr[k*AW +: AW] = (i % 16 == 0)
          ? AW'($urandom) : AW'($urandom_range(0, 7));
      step();
      checks++;
      if (bus.rd_data !== exp_rd || bus.rd_busy !== exp_rb
          || bus.busy_vec !== mbusy) begin
        errors++;
        $display("FAIL random[%0d] got %h %b %h want %h %b %h",
                 i, bus.rd_data, bus.rd_busy, bus.busy_vec,
                 exp_rd, exp_rb, mbusy);
      end
    end
  endtask

  task automatic test_reset();
    idle();
    bus.wr_en    = 2'b11;
    bus.wr_addr  = {AW'(20), AW'(21)};
    bus.wr_data  = {32'hA5A5, 32'h5A5A};
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = AW'(22);
    bus.rd_en    = 2'b11;
    bus.rd_addr  = {AW'(7), AW'(5)};
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus.rd_data !== '0 || bus.rd_busy !== '0
        || bus.busy_vec !== '0) begin
      errors++;
      $display("FAIL reset_async got %h %b %h want 0",
               bus.rd_data, bus.rd_busy, bus.busy_vec);
    end
    idle();
    @(posedge clk);
    #3;
    rst = 1'b1;
    for (int i = 0; i < NR / 2; i++) begin
      bus.rd_en   = 2'b11;
      bus.rd_addr = {AW'(2*i+1), AW'(2*i)};
      step();
      checks++;
      if (bus.rd_data !== '0 || bus.rd_data !== exp_rd
          || bus.busy_vec !== '0) begin
        errors++;
        $display("FAIL reset_regs[%0d] got %h %h want 0",
                 i, bus.rd_data, bus.busy_vec);
      end
    end
  endtask

  initial begin
    test_power_on();
    test_basic();
    test_conflict();
    test_zero();
    test_scoreboard();
    test_enable_flush();
    test_random();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
